// File: rtl/cprv_muldiv.sv
// Multi-cycle RV64M unit: one radix-2 shift-add multiplier / restoring divider
// shared by all M-extension ops, with valid/ready request and response.
module cprv_muldiv #(
  parameter int DATA_WIDTH    = 64,
  parameter int W_WIDTH       = 32,
  parameter int REGADDR_WIDTH = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [2:0]               req_funct3,
  input  logic                     req_is_w,
  input  logic [REGADDR_WIDTH-1:0] req_rd,
  input  logic [DATA_WIDTH-1:0]    req_data1,
  input  logic [DATA_WIDTH-1:0]    req_data2,
  input  logic                     flush,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [DATA_WIDTH-1:0]    resp_data,
  output logic [REGADDR_WIDTH-1:0] resp_rd,
  output logic                     busy
);
  localparam int DW = DATA_WIDTH;
  localparam int WW = W_WIDTH;
  localparam int CW = $clog2(DW + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t          state;
  logic [2*DW-1:0] acc;
  logic [DW-1:0]   opnd;
  logic [CW-1:0]   cnt;
  logic [2:0]      f3_q;
  logic            w_q;
  logic            neg_q;

  function automatic logic [DW-1:0] sext_w(input logic [WW-1:0] v);
    return {{(DW-WW){v[WW-1]}}, v};
  endfunction

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  // Request decode; W-form funct3 001..011 is folded onto MULW.
  logic [2:0]    f3_eff;
  logic          is_div, is_rem, sgn_a, sgn_b, neg_a, neg_b;
  logic [DW-1:0] op_a, op_b, mag_a, mag_b, min_neg, spec_raw, spec_res;
  logic          div_zero, ovf, special, neg_res;

  always_comb begin
    f3_eff   = (req_is_w && !req_funct3[2]) ? 3'b000 : req_funct3;
    is_div   = f3_eff[2];
    is_rem   = f3_eff[2] & f3_eff[1];
    sgn_a    = (f3_eff == 3'b001) || (f3_eff == 3'b010) || (f3_eff == 3'b100) || (f3_eff == 3'b110);
    sgn_b    = (f3_eff == 3'b001) || (f3_eff == 3'b100) || (f3_eff == 3'b110);
    op_a     = !req_is_w ? req_data1 :
               sgn_a ? sext_w(req_data1[WW-1:0]) : {{(DW-WW){1'b0}}, req_data1[WW-1:0]};
    op_b     = !req_is_w ? req_data2 :
               sgn_b ? sext_w(req_data2[WW-1:0]) : {{(DW-WW){1'b0}}, req_data2[WW-1:0]};
    neg_a    = sgn_a & op_a[DW-1];
    neg_b    = sgn_b & op_b[DW-1];
    mag_a    = neg_a ? -op_a : op_a;
    mag_b    = neg_b ? -op_b : op_b;
    min_neg  = req_is_w ? {{(DW-WW+1){1'b1}}, {(WW-1){1'b0}}} : {1'b1, {(DW-1){1'b0}}};
    div_zero = is_div && (op_b == '0);
    ovf      = is_div && !f3_eff[0] && (op_a == min_neg) && (op_b == '1);
    special  = div_zero || ovf;
    spec_raw = div_zero ? (is_rem ? op_a : '1) : (is_rem ? '0 : op_a);
    spec_res = req_is_w ? sext_w(spec_raw[WW-1:0]) : spec_raw;
    // Remainder follows the dividend; quotient and product follow a^b.
    neg_res  = is_rem ? neg_a : (neg_a ^ neg_b);
  end

  // One iteration of either datapath; acc = {hi/remainder, lo/quotient}.
  logic [DW:0]     mul_sum, div_part, div_diff;
  logic            div_ge;
  logic [2*DW-1:0] mul_next, div_next;

  always_comb begin
    mul_sum  = {1'b0, acc[2*DW-1:DW]} + (acc[0] ? {1'b0, opnd} : '0);
    mul_next = {mul_sum, acc[DW-1:1]};
    div_part = {acc[2*DW-1:DW], acc[DW-1]};
    div_diff = div_part - {1'b0, opnd};
    div_ge   = !div_diff[DW];
    div_next = {div_ge ? div_diff[DW-1:0] : div_part[DW-1:0], acc[DW-2:0], div_ge};
  end

  // W multiplies run half the iterations, leaving the product shifted up by WW.
  logic [2*DW-1:0] prod, prod_s;
  logic [DW-1:0]   mul_res, div_res, div_s, res, fix_res;

  always_comb begin
    prod    = w_q ? (acc >> WW) : acc;
    prod_s  = neg_q ? -prod : prod;
    mul_res = (f3_q[1:0] == 2'b00) ? prod_s[DW-1:0] : prod_s[2*DW-1:DW];
    div_res = f3_q[1] ? acc[2*DW-1:DW] : acc[DW-1:0];
    div_s   = neg_q ? -div_res : div_res;
    res     = f3_q[2] ? div_s : mul_res;
    fix_res = w_q ? sext_w(res[WW-1:0]) : res;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_rd    <= '0;
      acc        <= '0;
      opnd       <= '0;
      cnt        <= '0;
      f3_q       <= '0;
      w_q        <= 1'b0;
      neg_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req_valid && !flush) begin
          f3_q    <= f3_eff;
          w_q     <= req_is_w;
          neg_q   <= neg_res;
          resp_rd <= req_rd;
          if (special) begin
            state      <= DONE;
            resp_valid <= 1'b1;
            resp_data  <= spec_res;
          end else begin
            state <= CALC;
            cnt   <= req_is_w ? CW'(WW - 1) : CW'(DW - 1);
            opnd  <= is_div ? mag_b : mag_a;
            acc   <= is_div ? {{DW{1'b0}}, (req_is_w ? (mag_a << WW) : mag_a)}
                            : {{DW{1'b0}}, mag_b};
          end
        end
        CALC: if (flush) begin
          state <= IDLE;
        end else begin
          acc <= f3_q[2] ? div_next : mul_next;
          if (cnt == '0) state <= FIX;
          else           cnt   <= cnt - 1'b1;
        end
        FIX: if (flush) begin
          state <= IDLE;
        end else begin
          resp_data  <= fix_res;
          resp_valid <= 1'b1;
          state      <= DONE;
        end
        DONE: if (flush || resp_ready) begin
          resp_valid <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/cprv_muldiv.md
Name: cprv_muldiv

Overview:
Multi-cycle RV64M execution unit that runs alongside the combinational ALU in the execute stage. It covers MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU and the W forms MULW/DIVW/DIVUW/REMW/REMUW. One radix-2 shift-add multiplier or restoring divider is shared by all ops and sequenced by an FSM. Execute-stage control talks to it over a valid/ready request/response handshake and holds the pipeline while busy is high.

Parameters:
DATA_WIDTH, 64, operand/result width (XLEN)
W_WIDTH, 32, width of W-form operations
REGADDR_WIDTH, 5, destination register tag width

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  unit can accept a request (high only in IDLE)
req_funct3  input  3  RV64M funct3 (000 MUL … 111 REMU)
req_is_w  input  1  1 = OP_32 W-form
req_rd  input  REGADDR_WIDTH  destination tag, returned unchanged
req_data1  input  DATA_WIDTH  rs1 value
req_data2  input  DATA_WIDTH  rs2 value
flush  input  1  kill the in-flight op (branch mispredict/trap)
resp_valid  output  1  result valid
resp_ready  input  1  consumer accepts result
resp_data  output  DATA_WIDTH  result
resp_rd  output  REGADDR_WIDTH  tag of the result
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; resp_valid=0; resp_data=0; resp_rd=0; busy=0; req_ready=1 once reset is released. Reset mid-operation abandons the op with no response.
- FSM states: IDLE, CALC, FIX, DONE.
- Accept (cycle 0) when req_valid && req_ready. Operands, funct3, is_w and rd are latched.
- W forms first reduce operands to 32 bits. Signed ops sign-extend them; unsigned ops zero-extend them.
- Iteration count is ITER = 64, or 32 for W forms.
- Special cases are detected at accept. From IDLE they go directly to DONE, so resp_valid is high at cycle 1:
  - Divide by zero (effective divisor 0): DIV/DIVU give all ones; REM/REMU give the effective dividend.
  - Signed overflow (effective dividend = most-negative, divisor = -1, DIV/REM only): DIV gives the dividend; REM gives 0.
  - W results are then sign-extended from bit 31.
- Normal path:
  - IDLE→CALC. Signed operands are converted to magnitudes. MULHSU treats only rs1 as signed. Result sign is recorded.
  - CALC performs one iteration per cycle for ITER cycles.
  - Multiply: 2*DATA_WIDTH accumulator, shift-add on the multiplier LSB.
  - Divide: restoring shift-subtract, producing quotient and remainder.
  - CALC→FIX after the last iteration. FIX (1 cycle) applies sign correction:
    - Quotient is negated if operand signs differ.
    - Remainder takes the sign of the dividend.
    - Product is negated if the result sign is negative.
  - FIX also selects the result:
    - MUL gives the low half; MULH/MULHSU/MULHU give the high half.
    - DIV* give the quotient; REM* give the remainder.
    - W forms give sext(result[31:0]).
  - FIX→DONE. resp_valid rises at cycle ITER+2: 66 for 64-bit ops, 34 for W ops.
- DONE holds resp_valid, resp_data and resp_rd stable until resp_ready. On resp_valid && resp_ready the FSM goes to IDLE and resp_valid=0 next cycle. No new request is accepted in the same cycle (req_ready=0 in DONE).
- req_is_w with funct3 001/010/011 is never issued by decode; if it occurs, the unit behaves as MULW.
- flush high in CALC or FIX: go to IDLE next cycle, with no response.
- flush high in DONE: drop the result (resp_valid=0 next cycle), go to IDLE.
- flush in IDLE: no effect, and a request presented in the same cycle is not accepted.
- flush wins over resp_ready in the same cycle.
- resp_data is not required to clear after handshake. It is only meaningful while resp_valid is high.

Test Plan:
- MUL 7 × -3 (0xFFFF_FFFF_FFFF_FFFD) → resp_data 0xFFFF_FFFF_FFFF_FFEB, resp_valid at cycle 66, resp_rd echoed.
- MULHU 0xFFFF_FFFF_FFFF_FFFF × 0xFFFF_FFFF_FFFF_FFFF → 0xFFFF_FFFF_FFFF_FFFE.
- MULH with the same operands → 0x0000_0000_0000_0000.
- DIV -7/2 → 0xFFFF_FFFF_FFFF_FFFD; REM -7%2 → 0xFFFF_FFFF_FFFF_FFFF; DIVUW 0xFFFF_FFFF_8000_0000 / 2 → 0x0000_0000_4000_0000 at cycle 34.
- Specials at cycle 1:
  - DIVU 5/0 → 0xFFFF_FFFF_FFFF_FFFF.
  - REM 5%0 → 5.
  - DIV 0x8000_0000_0000_0000 / -1 → 0x8000_0000_0000_0000.
  - REM of the same operands → 0.
  - DIVW 0x0000_0001_8000_0000 / 0xFFFF_FFFF_FFFF_FFFF → 0xFFFF_FFFF_8000_0000.
- Backpressure: hold resp_ready=0 for 10 cycles in DONE → resp_valid, resp_data and resp_rd stable, req_ready=0. Release → IDLE the cycle after the handshake; back-to-back request accepted then.
- flush at cycle 20 of a DIV → no resp_valid ever, busy=0 next cycle. Repeat with async rst_n low mid-CALC → all outputs reset immediately.
